// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S transmit scheduler.
// No logic lives here; FSM encoding, source ids and counter width only.
package i2s_pkg;
   typedef enum logic {
      WAIT_L = 1'b0,
      WAIT_R = 1'b1
   } state_t;

   localparam logic SRC_MAIN       = 1'b0;
   localparam logic SRC_ALT        = 1'b1;
   localparam int   UNDERRUN_CNT_W = 16;
endpackage

// File: rtl/i2s_tx_scheduler_if.sv
// Stream, control and status bundle of the I2S scheduler.
// slave = scheduler view, master = environment (sources, transmitter, control) view.
interface i2s_tx_scheduler_if #(parameter int DATA_WIDTH = 32);
   import i2s_pkg::*;

   logic                      enable;
   logic                      sel;
   logic [DATA_WIDTH-1:0]     S0_AXIS_TDATA;
   logic                      S0_AXIS_TLAST;
   logic                      S0_AXIS_TVALID;
   logic                      S0_AXIS_TREADY;
   logic [DATA_WIDTH-1:0]     S1_AXIS_TDATA;
   logic                      S1_AXIS_TLAST;
   logic                      S1_AXIS_TVALID;
   logic                      S1_AXIS_TREADY;
   logic [DATA_WIDTH-1:0]     M_AXIS_TDATA;
   logic                      M_AXIS_TLAST;
   logic                      M_AXIS_TVALID;
   logic                      M_AXIS_TREADY;
   logic                      sck;
   logic                      ws;
   logic                      cur_sel;
   logic                      proto_err;
   logic [UNDERRUN_CNT_W-1:0] underrun_cnt;

   modport slave (
      input  enable, sel,
      input  S0_AXIS_TDATA, S0_AXIS_TLAST, S0_AXIS_TVALID,
      output S0_AXIS_TREADY,
      input  S1_AXIS_TDATA, S1_AXIS_TLAST, S1_AXIS_TVALID,
      output S1_AXIS_TREADY,
      output M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TVALID,
      input  M_AXIS_TREADY,
      output sck, ws, cur_sel, proto_err, underrun_cnt
   );

   modport master (
      output enable, sel,
      output S0_AXIS_TDATA, S0_AXIS_TLAST, S0_AXIS_TVALID,
      input  S0_AXIS_TREADY,
      output S1_AXIS_TDATA, S1_AXIS_TLAST, S1_AXIS_TVALID,
      input  S1_AXIS_TREADY,
      input  M_AXIS_TDATA, M_AXIS_TLAST, M_AXIS_TVALID,
      output M_AXIS_TREADY,
      input  sck, ws, cur_sel, proto_err, underrun_cnt
   );
endinterface

// File: rtl/i2s_clkgen.sv
// I2S sck/ws generator: sck toggles every SCK_DIV clocks, ws toggles with the sck fall ending a channel.
// o_ws_tgl is combinational and marks the cycle whose closing edge flips ws; no backpressure.
module i2s_clkgen #(
   parameter int SCK_DIV          = 4,
   parameter int BITS_PER_CHANNEL = 32
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_enable,
   output logic o_sck,
   output logic o_ws,
   output logic o_ws_tgl
);
   localparam int DW = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
   localparam int BW = (BITS_PER_CHANNEL > 1) ? $clog2(BITS_PER_CHANNEL) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(SCK_DIV - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_CHANNEL - 1);

   logic [DW-1:0] r_div_cnt;
   logic [BW-1:0] r_bit_cnt;
   logic          r_sck;
   logic          r_ws;
   logic          w_div_wrap;
   logic          w_fall;
   logic          w_bit_wrap;

   assign w_div_wrap = (r_div_cnt == DIV_LAST);
   assign w_fall     = w_div_wrap & r_sck;
   assign w_bit_wrap = (r_bit_cnt == BIT_LAST);
   assign o_ws_tgl   = i_enable & w_fall & w_bit_wrap;

   // Disabling behaves like a local reset so re-enable restarts a clean frame.
   always_ff @(posedge i_clk) begin
      if (i_rst || !i_enable) begin
         r_div_cnt <= '0;
         r_bit_cnt <= '0;
         r_sck     <= 1'b0;
         r_ws      <= 1'b0;
      end else begin
         r_div_cnt <= w_div_wrap ? '0 : r_div_cnt + 1'b1;
         if (w_div_wrap) r_sck <= ~r_sck;
         if (w_fall) begin
            r_bit_cnt <= w_bit_wrap ? '0 : r_bit_cnt + 1'b1;
            if (w_bit_wrap) r_ws <= ~r_ws;
         end
      end
   end

   assign o_sck = r_sck;
   assign o_ws  = r_ws;
endmodule

// File: rtl/i2s_tx_scheduler.sv
// I2S master scheduler: sck/ws generation plus frame-aligned S0/S1 arbitration; optional I2S_SCHED_UNDERRUN_CNT_EN counter.
// Zero-latency combinational data path; granted source sees M_AXIS_TREADY, the other sees 0.
module i2s_tx_scheduler
   import i2s_pkg::*;
#(
   parameter int DATA_WIDTH       = 32,
   parameter int SCK_DIV          = 4,
   parameter int BITS_PER_CHANNEL = 32
) (
   input  logic                S_AXIS_ACLK,
   input  logic                S_AXIS_ARESET,
   i2s_tx_scheduler_if.slave   axis
);
   state_t                r_state;
   logic                  r_cur_sel;
   logic                  r_proto_err;
   logic [DATA_WIDTH-1:0] w_tdata;
   logic                  w_tlast;
   logic                  w_tvalid;
   logic                  w_hs;
   logic                  w_ws_tgl;
   logic                  w_sck;
   logic                  w_ws;

   i2s_clkgen #(
      .SCK_DIV          (SCK_DIV),
      .BITS_PER_CHANNEL (BITS_PER_CHANNEL)
   ) u_clkgen (
      .i_clk    (S_AXIS_ACLK),
      .i_rst    (S_AXIS_ARESET),
      .i_enable (axis.enable),
      .o_sck    (w_sck),
      .o_ws     (w_ws),
      .o_ws_tgl (w_ws_tgl)
   );

   assign w_tdata  = (r_cur_sel == SRC_ALT) ? axis.S1_AXIS_TDATA  : axis.S0_AXIS_TDATA;
   assign w_tlast  = (r_cur_sel == SRC_ALT) ? axis.S1_AXIS_TLAST  : axis.S0_AXIS_TLAST;
   assign w_tvalid = (r_cur_sel == SRC_ALT) ? axis.S1_AXIS_TVALID : axis.S0_AXIS_TVALID;
   assign w_hs     = w_tvalid & axis.M_AXIS_TREADY;

   assign axis.M_AXIS_TDATA   = w_tdata;
   assign axis.M_AXIS_TLAST   = w_tlast;
   assign axis.M_AXIS_TVALID  = w_tvalid;
   assign axis.S0_AXIS_TREADY = (r_cur_sel == SRC_MAIN) & axis.M_AXIS_TREADY;
   assign axis.S1_AXIS_TREADY = (r_cur_sel == SRC_ALT)  & axis.M_AXIS_TREADY;
   assign axis.sck            = w_sck;
   assign axis.ws             = w_ws;
   assign axis.cur_sel        = r_cur_sel;
   assign axis.proto_err      = r_proto_err;

   // Out-of-order beats are still forwarded; only a right beat (or a stray right in WAIT_L) may change source.
   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         r_state     <= WAIT_L;
         r_cur_sel   <= SRC_MAIN;
         r_proto_err <= 1'b0;
      end else if (w_hs) begin
         case (r_state)
            WAIT_L: begin
               if (w_tlast) begin
                  r_proto_err <= 1'b1;
                  r_cur_sel   <= axis.sel;
               end else begin
                  r_state <= WAIT_R;
               end
            end
            WAIT_R: begin
               if (w_tlast) begin
                  r_state   <= WAIT_L;
                  r_cur_sel <= axis.sel;
               end else begin
                  r_proto_err <= 1'b1;
               end
            end
         endcase
      end
   end

`ifdef I2S_SCHED_UNDERRUN_CNT_EN
   logic [UNDERRUN_CNT_W-1:0] r_underrun_cnt;

   always_ff @(posedge S_AXIS_ACLK) begin
      if (S_AXIS_ARESET) begin
         r_underrun_cnt <= '0;
      end else if (w_ws_tgl && axis.M_AXIS_TREADY && !w_tvalid && (r_underrun_cnt != '1)) begin
         r_underrun_cnt <= r_underrun_cnt + 1'b1;
      end
   end

   assign axis.underrun_cnt = r_underrun_cnt;
`else
   logic w_unused_ws_tgl;
   assign w_unused_ws_tgl   = w_ws_tgl;
   assign axis.underrun_cnt = '0;
`endif
endmodule

// File: tb/tb_i2s_tx_scheduler.sv
// Bench for i2s_tx_scheduler: directed steps plus random traffic against an arithmetic reference model.
module tb_i2s_tx_scheduler;
   import i2s_pkg::*;

   localparam int DW   = 32;
   localparam int SD   = 2;
   localparam int BPC  = 32;
   localparam int HALF = 2 * SD * BPC;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad   = 0;

   // Reference state: enabled-edge count drives sck/ws arithmetically.
   int          m_n;
   logic        m_sel;
   logic        m_right;
   logic        m_err;
   logic [15:0] m_under;

   i2s_tx_scheduler_if #(.DATA_WIDTH(DW)) bus();

   i2s_tx_scheduler #(
      .DATA_WIDTH       (DW),
      .SCK_DIV          (SD),
      .BITS_PER_CHANNEL (BPC)
   ) dut (
      .S_AXIS_ACLK   (clk),
      .S_AXIS_ARESET (rst),
      .axis          (bus)
   );

   initial forever #5 clk = ~clk;

   function automatic int exp_sck();
      return (m_n / SD) % 2;
   endfunction

   function automatic int exp_bit();
      return (m_n / (2 * SD)) % BPC;
   endfunction

   function automatic int exp_ws();
      return ((m_n / (2 * SD)) / BPC) % 2;
   endfunction

   task automatic model_reset();
      m_n     = 0;
      m_sel   = 1'b0;
      m_right = 1'b0;
      m_err   = 1'b0;
      m_under = 16'd0;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: check all outputs at negedge, advance the model, return at posedge+1.
   task automatic tick();
      logic [31:0] edat;
      logic        elast;
      logic        evld;
      logic        hs;
      @(negedge clk);
      edat  = m_sel ? bus.S1_AXIS_TDATA  : bus.S0_AXIS_TDATA;
      elast = m_sel ? bus.S1_AXIS_TLAST  : bus.S0_AXIS_TLAST;
      evld  = m_sel ? bus.S1_AXIS_TVALID : bus.S0_AXIS_TVALID;
      chk("m_tdata",   bus.M_AXIS_TDATA, edat);
      chk("m_tlast",   32'(bus.M_AXIS_TLAST), 32'(elast));
      chk("m_tvalid",  32'(bus.M_AXIS_TVALID), 32'(evld));
      chk("s0_tready", 32'(bus.S0_AXIS_TREADY), 32'(!m_sel && bus.M_AXIS_TREADY));
      chk("s1_tready", 32'(bus.S1_AXIS_TREADY), 32'(m_sel && bus.M_AXIS_TREADY));
      chk("sck",       32'(bus.sck), 32'(exp_sck()));
      chk("ws",        32'(bus.ws), 32'(exp_ws()));
      chk("cur_sel",   32'(bus.cur_sel), 32'(m_sel));
      chk("proto_err", 32'(bus.proto_err), 32'(m_err));
      chk("underrun",  32'(bus.underrun_cnt), 32'(m_under));
      hs = evld && bus.M_AXIS_TREADY;
      if (rst) begin
         model_reset();
      end else begin
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
         if (bus.enable && ((m_n + 1) % HALF == 0) && bus.M_AXIS_TREADY && !evld && m_under != 16'hFFFF)
            m_under = m_under + 16'd1;
`endif
         m_n = bus.enable ? m_n + 1 : 0;
         if (hs) begin
            if (!m_right) begin
               if (elast) begin
                  m_err = 1'b1;
                  m_sel = bus.sel;
               end else begin
                  m_right = 1'b1;
               end
            end else begin
               if (elast) begin
                  m_right = 1'b0;
                  m_sel   = bus.sel;
               end else begin
                  m_err = 1'b1;
               end
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic s0_beat(input logic [31:0] d, input logic last);
      bus.S0_AXIS_TDATA  = d;
      bus.S0_AXIS_TLAST  = last;
      bus.S0_AXIS_TVALID = 1'b1;
      bus.M_AXIS_TREADY  = 1'b1;
      tick();
      bus.S0_AXIS_TVALID = 1'b0;
      bus.M_AXIS_TREADY  = 1'b0;
   endtask

   task automatic s1_beat(input logic [31:0] d, input logic last);
      bus.S1_AXIS_TDATA  = d;
      bus.S1_AXIS_TLAST  = last;
      bus.S1_AXIS_TVALID = 1'b1;
      bus.M_AXIS_TREADY  = 1'b1;
      tick();
      bus.S1_AXIS_TVALID = 1'b0;
      bus.M_AXIS_TREADY  = 1'b0;
   endtask

   initial begin
      int   last_t;
      logic prev_ws;

      bus.enable = 1'b0;
      bus.sel = 1'b0;
      bus.S0_AXIS_TDATA = '0;
      bus.S0_AXIS_TLAST = 1'b0;
      bus.S0_AXIS_TVALID = 1'b0;
      bus.S1_AXIS_TDATA = '0;
      bus.S1_AXIS_TLAST = 1'b0;
      bus.S1_AXIS_TVALID = 1'b0;
      bus.M_AXIS_TREADY = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      repeat (3) tick();
      rst = 1'b0;
      repeat (2) tick();

      // Clock generation from a clean enable.
      bus.enable = 1'b1;
      tick();
      chk("sck_before_rise", 32'(bus.sck), 32'd0);
      tick();
      chk("first_rise", 32'(bus.sck), 32'd1);
      last_t = -1;
      for (int i = 0; i < 300; i++) begin
         prev_ws = bus.ws;
         tick();
         if (bus.ws !== prev_ws) begin
            chk("ws_at_sck_fall", 32'(bus.sck), 32'd0);
            if (last_t >= 0) chk("ws_period", 32'(i - last_t), 32'(HALF));
            last_t = i;
         end
      end

      // Plain S0 frame.
      bus.S0_AXIS_TDATA  = 32'hAAAA0001;
      bus.S0_AXIS_TLAST  = 1'b0;
      bus.S0_AXIS_TVALID = 1'b1;
      tick();
      s0_beat(32'hAAAA0001, 1'b0);
      s0_beat(32'h55550002, 1'b1);
      chk("pair_err", 32'(bus.proto_err), 32'd0);

      // Source switch lands only at the frame boundary.
      s0_beat(32'hAAAA0011, 1'b0);
      bus.sel = 1'b1;
      chk("switch_mid_frame", 32'(bus.cur_sel), 32'd0);
      s0_beat(32'h55550012, 1'b1);
      chk("switch_cur_sel", 32'(bus.cur_sel), 32'd1);
      bus.S0_AXIS_TDATA  = 32'hDEADBEEF;
      bus.S0_AXIS_TVALID = 1'b1;
      bus.S1_AXIS_TDATA  = 32'h11110003;
      bus.S1_AXIS_TLAST  = 1'b0;
      bus.S1_AXIS_TVALID = 1'b1;
      bus.M_AXIS_TREADY  = 1'b1;
      #1;
      chk("switch_src", bus.M_AXIS_TDATA, 32'h11110003);
      chk("switch_s0_rdy", 32'(bus.S0_AXIS_TREADY), 32'd0);
      tick();
      bus.S0_AXIS_TVALID = 1'b0;
      bus.sel = 1'b0;
      s1_beat(32'h22220004, 1'b1);
      chk("switch_back", 32'(bus.cur_sel), 32'd0);

      // Two lefts in a row.
      s0_beat(32'h0000A001, 1'b0);
      s0_beat(32'h0000A002, 1'b0);
      chk("dbl_left_err", 32'(bus.proto_err), 32'd1);
      s0_beat(32'h0000A003, 1'b1);
      s0_beat(32'h0000A004, 1'b0);
      s0_beat(32'h0000A005, 1'b1);
      chk("err_sticky", 32'(bus.proto_err), 32'd1);

      // Random traffic, occasional enable drops.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         bus.enable         = ($urandom_range(0, 299) != 0);
         bus.sel            = 1'($urandom_range(0, 1));
         bus.S0_AXIS_TDATA  = $urandom;
         bus.S0_AXIS_TLAST  = 1'($urandom_range(0, 1));
         bus.S0_AXIS_TVALID = 1'($urandom_range(0, 1));
         bus.S1_AXIS_TDATA  = $urandom;
         bus.S1_AXIS_TLAST  = 1'($urandom_range(0, 1));
         bus.S1_AXIS_TVALID = 1'($urandom_range(0, 1));
         bus.M_AXIS_TREADY  = ($urandom_range(0, 3) != 0);
         tick();
      end

      // Underrun across three ws toggles.
      bus.enable = 1'b1;
      bus.sel = 1'b0;
      bus.S0_AXIS_TVALID = 1'b0;
      bus.S1_AXIS_TVALID = 1'b0;
      bus.M_AXIS_TREADY = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      bus.M_AXIS_TREADY = 1'b1;
      repeat (3 * HALF + 10) tick();
`ifdef I2S_SCHED_UNDERRUN_CNT_EN
      chk("underrun3", 32'(bus.underrun_cnt), 32'd3);
      force dut.r_underrun_cnt = 16'hFFFE;
      #1;
      release dut.r_underrun_cnt;
      m_under = 16'hFFFE;
      repeat (2 * HALF) tick();
      chk("underrun_sat", 32'(bus.underrun_cnt), 32'hFFFF);
`else
      chk("underrun3", 32'(bus.underrun_cnt), 32'd0);
`endif
      bus.M_AXIS_TREADY = 1'b0;

      // Mid-frame reset at bit 17 with non-reset state everywhere.
      bus.sel = 1'b1;
      s0_beat(32'h00000031, 1'b0);
      s0_beat(32'h00000032, 1'b1);
      s1_beat(32'h00000033, 1'b0);
      s1_beat(32'h00000034, 1'b0);
      for (int i = 0; i < 600 && exp_bit() != 17; i++) tick();
      rst = 1'b1;
      tick();
      chk("rst_sck", 32'(bus.sck), 32'd0);
      chk("rst_ws", 32'(bus.ws), 32'd0);
      chk("rst_cur_sel", 32'(bus.cur_sel), 32'd0);
      chk("rst_proto_err", 32'(bus.proto_err), 32'd0);
      chk("rst_state", 32'(dut.r_state), 32'(WAIT_L));
      rst = 1'b0;
      repeat (8) tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/i2s_tx_scheduler.md
Name: i2s_tx_scheduler

Overview:
- Master-side controller for the I2S stereo transmitter.
- Generates the I2S bit clock (sck) and word select (ws) from the system clock.
- Arbitrates two AXI-Stream stereo sample sources (S0 = main audio, S1 = alternate/test audio) onto the single stream that feeds the transmitter, switching sources only on stereo-frame boundaries.
- Reports protocol errors and transmitter underruns.

Parameters:
- DATA_WIDTH, 32, sample width on all streams.
- SCK_DIV, 4, system clocks per sck half-period; legal range 2 or more.
- BITS_PER_CHANNEL, 32, sck periods per ws half-frame; must be ≥ DATA_WIDTH.

Ports:
- S_AXIS_ACLK  in  1  system clock.
- S_AXIS_ARESET  in  1  synchronous, active-high reset.
- enable  in  1  1 = run sck/ws generation.
- sel  in  1  requested source: 0 = S0, 1 = S1.
- S0_AXIS_TDATA  in  DATA_WIDTH  source 0 sample.
- S0_AXIS_TLAST  in  1  source 0: 0 = left, 1 = right.
- S0_AXIS_TVALID  in  1  source 0 valid.
- S0_AXIS_TREADY  out  1  source 0 ready.
- S1_AXIS_TDATA, S1_AXIS_TLAST, S1_AXIS_TVALID, S1_AXIS_TREADY: same as S0, for source 1.
- M_AXIS_TDATA  out  DATA_WIDTH  sample to transmitter.
- M_AXIS_TLAST  out  1  channel flag to transmitter.
- M_AXIS_TVALID  out  1  valid to transmitter.
- M_AXIS_TREADY  in  1  ready from transmitter.
- sck  out  1  I2S bit clock.
- ws  out  1  I2S word select: 0 = left, 1 = right.
- cur_sel  out  1  currently granted source.
- proto_err  out  1  sticky channel-order error flag.
- underrun_cnt  out  16  saturating underrun count.

Behaviour:
- Reset values: sck = 0, ws = 0, cur_sel = 0, proto_err = 0, underrun_cnt = 0, divider and bit counters = 0, FSM = WAIT_L.
- Clock generation:
  - div_cnt counts 0..SCK_DIV-1; at terminal count it wraps and sck toggles. sck period = 2·SCK_DIV clocks.
  - bit_cnt advances on each sck falling toggle, 0..BITS_PER_CHANNEL-1. On wrap, ws toggles in the same cycle as the sck fall, giving standard I2S one-bit MSB delay at the transmitter.
  - Frame = 2·BITS_PER_CHANNEL·2·SCK_DIV clocks.
- enable = 0:
  - Counters are cleared, sck and ws are held 0.
  - Stream arbitration continues.
  - Re-enable starts from bit_cnt = 0, ws = 0; the first sck rise occurs SCK_DIV clocks later.
- Arbitration FSM (registered state, combinational data mux):
  - WAIT_L: granted source is cur_sel.
    - M_AXIS_TDATA/TLAST/TVALID = granted source's signals; granted TREADY = M_AXIS_TREADY; non-granted TREADY = 0.
    - Accepted beat with TLAST = 0 → WAIT_R.
    - Accepted beat with TLAST = 1: beat is still forwarded; proto_err set; state remains WAIT_L; cur_sel resampled.
  - WAIT_R: same mux.
    - Accepted beat with TLAST = 1 → WAIT_L; cur_sel <= sel in the same cycle (frame boundary).
    - Accepted beat with TLAST = 0: forwarded; proto_err set; state remains WAIT_R.
  - A change on sel mid-frame has no effect until the right beat is accepted; the switch latency is 1 clock after that handshake.
  - Zero combinational-path latency data→M; no buffering; AXIS rules hold (TVALID not dependent on TREADY).
- Underrun:
  - Condition: in the cycle ws toggles, M_AXIS_TREADY = 1 and M_AXIS_TVALID = 0. The transmitter is about to load a stale sample.
  - underrun_cnt increments, saturating at 0xFFFF.
  - Not counted while enable = 0.
- Reset mid-frame: all state returns to reset values next clock; any partial frame is discarded; sck drops to 0 immediately.
- proto_err is cleared only by reset.

Optional Feature:
- I2S_SCHED_UNDERRUN_CNT_EN:
  - Defined: underrun detection and 16-bit saturating counter are present as described.
  - Undefined: logic is omitted; underrun_cnt is tied to 0; all other behaviour is identical.

Decomposition:
- Shared package i2s_pkg:
  - FSM state encoding: WAIT_L = 1'b0, WAIT_R = 1'b1.
  - Source select constants SRC_MAIN = 0, SRC_ALT = 1.
  - UNDERRUN_CNT_W = 16.
- Sub-module i2s_clkgen: div_cnt, bit_cnt, sck/ws generation and a ws-toggle strobe output. The top-level module holds the arbiter FSM and counters.

Test Plan (SCK_DIV = 2, BITS_PER_CHANNEL = 32, DATA_WIDTH = 32):
- Reset then enable = 1 → sck period 4 clocks; first sck rise 2 clocks after enable; ws toggles every 128 clocks, coincident with an sck fall.
- S0 supplies pairs (0xAAAA0001, L), (0x5555_0002, R) with sel = 0; M_AXIS_TREADY pulses → identical beats on M; S1_AXIS_TREADY stays 0; proto_err = 0.
- sel 0→1 after the S0 left beat is accepted → S0 right beat still forwarded; cur_sel = 1 one clock after the right handshake; next beat comes from S1.
- S0 sends two consecutive TLAST = 0 beats → both forwarded; proto_err = 1 and remains 1 until reset.
- Hold S0_AXIS_TVALID = 0 while M_AXIS_TREADY = 1 across 3 ws toggles → underrun_cnt = 3 (macro defined) or 0 (macro undefined); preload near 0xFFFF → saturates at 0xFFFF.
- Assert reset mid-frame at bit_cnt = 17 → next clock sck = 0, ws = 0, cur_sel = 0, FSM = WAIT_L, proto_err = 0.
